memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset. All state SHALL change only on posedge clk.
REQ-002 Parameters (name, default, meaning) SHALL be:
- ADDR_BITS, MEMORY_ADDRESS_BITS (8): address width.
- DATA_BITS, MEMORY_DATA_BITS (8): data width.
- IO_ADDR, 8'hFF: memory-mapped I/O address.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: clock.
- reset, in, 1: synchronous active-high reset.
- rd_ram_en, in, 1: read request.
- rd_ram_addr, in, ADDR_BITS: read address.
- rd_ram_data, out, DATA_BITS: registered read data.
- wr_ram_en, in, 1: write request.
- wr_ram_addr, in, ADDR_BITS: write address.
- wr_ram_data, in, DATA_BITS: write data (may be Z while wr_ram_en=0).
- load_valid, in, 1: loader byte valid.
- load_data, in, DATA_BITS: loader byte.
- load_last, in, 1: final loader byte.
- load_ready, out, 1: loader may transfer.
- hold_cpu, out, 1: holds the execution unit in reset.
- io_in_data, in, DATA_BITS: external input byte.
- io_out_data, out, DATA_BITS: last byte written to IO_ADDR.
- io_out_valid, out, 1: one-cycle strobe on an IO_ADDR write.

Function
REQ-004 The state machine SHALL have two states, LOAD and RUN. Reset SHALL enter LOAD.
REQ-005 In LOAD:
- load_ready=1 and hold_cpu=1.
- Each cycle with load_valid=1 SHALL write load_data to mem[load_ptr], then increment load_ptr.
- load_ptr SHALL start at 0.
REQ-006 LOAD SHALL transition to RUN on the edge that accepts a byte with load_last=1, or that accepts the byte at load_ptr=2^ADDR_BITS-1. The pointer SHALL never wrap.
REQ-007 In RUN: load_ready=0, hold_cpu=0, and load_valid SHALL be ignored.
REQ-008 Reads in RUN: on an edge with rd_ram_en=1, rd_ram_data SHALL take mem[rd_ram_addr], with one-cycle latency. With rd_ram_en=0, rd_ram_data SHALL hold its value.
REQ-009 A read of IO_ADDR SHALL return io_in_data as sampled on that edge, not the memory contents.
REQ-010 Writes in RUN: on an edge with wr_ram_en=1 and wr_ram_addr≠IO_ADDR, the block SHALL write wr_ram_data to memory. With wr_ram_en=0, wr_ram_data SHALL be ignored, including Z values.
REQ-011 A write to IO_ADDR SHALL update io_out_data and pulse io_out_valid for exactly one cycle. Memory SHALL be unchanged.
REQ-012 A same-edge read and write to the same non-IO address SHALL return the new write data (write-first forwarding).
REQ-013 Back-to-back IO_ADDR writes SHALL hold io_out_valid high on consecutive cycles, with the data updated each cycle.
REQ-014 In LOAD, rd_ram_en and wr_ram_en SHALL be ignored, and rd_ram_data SHALL hold.

Reset
REQ-015 Reset SHALL set the following values:
- state=LOAD, load_ptr=0.
- rd_ram_data=0, io_out_data=0, io_out_valid=0.
- load_ready=1, hold_cpu=1.
REQ-016 Memory contents SHALL NOT be cleared by reset.
REQ-017 Reset asserted mid-load or mid-run SHALL abandon the operation in progress, re-enter LOAD with load_ptr=0, and drop any write on that edge.

Structure
REQ-018 The following SHALL live in constants_pkg, alongside MEMORY_ADDRESS_BITS and MEMORY_DATA_BITS:
- the MemResponderState enum {LOAD, RUN};
- the IO_ADDRESS constant (8'hFF).
REQ-019 The storage SHALL be one sub-module, ram_array: a 2^ADDR_BITS x DATA_BITS array with one synchronous write port and one read port. Loader and RUN writes SHALL be muxed onto its single write port.

Verification
REQ-020 Load test: load bytes 10,20,30 with load_last on 30 -> load_ready and hold_cpu drop the next cycle; in RUN, reading addr 1 gives 8'h14 one cycle later.
REQ-021 Pointer-limit test: stream 256 bytes without load_last -> RUN is entered after byte 255; the 257th load_valid has no effect and mem[0] is unchanged.
REQ-022 Forwarding test: in RUN, mem[5]=8'hAA; write 8'h55 to addr 5 with a same-edge read of addr 5 -> rd_ram_data=8'h55.
REQ-023 IO test:
- Write 8'h3C then 8'h3D to 8'hFF on back-to-back cycles -> io_out_valid is high for 2 cycles, io_out_data is 3C then 3D, and mem[FF] is unchanged.
- io_in_data=8'h99 and a read of FF -> 8'h99.
REQ-024 Reset test: assert reset in RUN during a write to addr 7 -> mem[7] is unchanged, the state is LOAD, and all outputs are at their REQ-015 values the next cycle.
REQ-025 Hold test: wr_ram_en=0 with wr_ram_data=Z for 20 cycles in RUN -> no memory or io_out changes.

Source files
------------

// File: rtl/constants_pkg.sv
// Shared constants and types for the memory responder.
//   MEMORY_ADDRESS_BITS / MEMORY_DATA_BITS : default memory geometry
//   IO_ADDRESS                             : memory-mapped I/O location
//   MemResponderState                      : LOAD (loader owns memory) / RUN (CPU owns memory)
package constants_pkg;
  localparam int MEMORY_ADDRESS_BITS = 8;
  localparam int MEMORY_DATA_BITS    = 8;
  localparam logic [7:0] IO_ADDRESS  = 8'hFF;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } MemResponderState;
endpackage

// File: rtl/ram_array.sv
// Storage array for the memory responder.
//   clk      : clock
//   wr_en    : synchronous write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : combinational read data (the caller registers it)
// Contents are never reset.
module ram_array #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);
  logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/memory_responder.sv
// Memory responder: a loader fills memory while the CPU is held in reset,
// then the CPU gets a read/write port with one memory-mapped I/O address.
//   clk, reset                       : clock, synchronous active-high reset
//   rd_ram_en/addr, rd_ram_data      : read request, registered read data
//   wr_ram_en/addr/data              : write request
//   load_valid/data/last, load_ready : loader byte stream (transfer = valid & ready)
//   hold_cpu                         : high while loading
//   io_in_data                       : value returned when reading IO_ADDR
//   io_out_data, io_out_valid        : last IO_ADDR write and its one-cycle strobe
//
// Loader handshake: a byte transfers on every edge where load_valid and
// load_ready are both high; load_ready depends only on state, never on
// load_valid, so the loader may hold valid indefinitely.
module memory_responder
  import constants_pkg::*;
#(
  parameter int                   ADDR_BITS = MEMORY_ADDRESS_BITS,
  parameter int                   DATA_BITS = MEMORY_DATA_BITS,
  parameter logic [ADDR_BITS-1:0] IO_ADDR   = IO_ADDRESS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_ram_en,
  input  logic [ADDR_BITS-1:0] rd_ram_addr,
  output logic [DATA_BITS-1:0] rd_ram_data,
  input  logic                 wr_ram_en,
  input  logic [ADDR_BITS-1:0] wr_ram_addr,
  input  logic [DATA_BITS-1:0] wr_ram_data,
  input  logic                 load_valid,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  output logic                 hold_cpu,
  input  logic [DATA_BITS-1:0] io_in_data,
  output logic [DATA_BITS-1:0] io_out_data,
  output logic                 io_out_valid
);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  MemResponderState     state_q, state_d;
  logic [ADDR_BITS-1:0] load_ptr_q, load_ptr_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic [DATA_BITS-1:0] io_out_data_q, io_out_data_d;
  logic                 io_out_valid_q, io_out_valid_d;

  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_waddr;
  logic [DATA_BITS-1:0] ram_wdata;
  logic [DATA_BITS-1:0] ram_rdata;

  ram_array #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ram_we),
    .wr_addr(ram_waddr),
    .wr_data(ram_wdata),
    .rd_addr(rd_ram_addr),
    .rd_data(ram_rdata)
  );

  always_comb begin
    state_d        = state_q;
    load_ptr_d     = load_ptr_q;
    rd_data_d      = rd_data_q;
    io_out_data_d  = io_out_data_q;
    io_out_valid_d = 1'b0;
    ram_we         = 1'b0;
    ram_waddr      = load_ptr_q;
    ram_wdata      = load_data;

    case (state_q)
      LOAD: begin
        if (load_valid) begin
          ram_we = 1'b1;
          // The pointer stops at the top address instead of wrapping.
          if (load_last || (load_ptr_q == LAST_ADDR)) begin
            state_d = RUN;
          end else begin
            load_ptr_d = load_ptr_q + 1'b1;
          end
        end
      end
      RUN: begin
        ram_waddr = wr_ram_addr;
        ram_wdata = wr_ram_data;
        if (wr_ram_en) begin
          if (wr_ram_addr == IO_ADDR) begin
            io_out_data_d  = wr_ram_data;
            io_out_valid_d = 1'b1;
          end else begin
            ram_we = 1'b1;
          end
        end
        if (rd_ram_en) begin
          if (rd_ram_addr == IO_ADDR) begin
            rd_data_d = io_in_data;
          end else if (wr_ram_en && (wr_ram_addr == rd_ram_addr)) begin
            // Write-first: the array still holds the old value this edge.
            rd_data_d = wr_ram_data;
          end else begin
            rd_data_d = ram_rdata;
          end
        end
      end
    endcase

    // A write coinciding with reset is dropped.
    if (reset) begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= LOAD;
      load_ptr_q     <= '0;
      rd_data_q      <= '0;
      io_out_data_q  <= '0;
      io_out_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_ptr_q     <= load_ptr_d;
      rd_data_q      <= rd_data_d;
      io_out_data_q  <= io_out_data_d;
      io_out_valid_q <= io_out_valid_d;
    end
  end

  assign rd_ram_data  = rd_data_q;
  assign io_out_data  = io_out_data_q;
  assign io_out_valid = io_out_valid_q;
  assign load_ready   = (state_q == LOAD);
  assign hold_cpu     = (state_q == LOAD);
endmodule

// File: tb/tb_memory_responder.sv
// Testbench for memory_responder: directed scenarios plus randomized RUN
// traffic, checked against a behavioural model of the memory map.
module tb_memory_responder;
  logic       clk;
  logic       reset;
  logic       rd_ram_en;
  logic [7:0] rd_ram_addr;
  logic [7:0] rd_ram_data;
  logic       wr_ram_en;
  logic [7:0] wr_ram_addr;
  logic [7:0] wr_ram_data;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       hold_cpu;
  logic [7:0] io_in_data;
  logic [7:0] io_out_data;
  logic       io_out_valid;

  int total = 0;
  int bad   = 0;

  // Behavioural model
  logic [7:0] m_mem [256];
  bit         m_loading;
  int         m_ptr;
  logic [7:0] m_rd;
  logic [7:0] m_io;
  bit         m_iov;

  memory_responder dut (
    .clk         (clk),
    .reset       (reset),
    .rd_ram_en   (rd_ram_en),
    .rd_ram_addr (rd_ram_addr),
    .rd_ram_data (rd_ram_data),
    .wr_ram_en   (wr_ram_en),
    .wr_ram_addr (wr_ram_addr),
    .wr_ram_data (wr_ram_data),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .hold_cpu    (hold_cpu),
    .io_in_data  (io_in_data),
    .io_out_data (io_out_data),
    .io_out_valid(io_out_valid)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge: update the model from the inputs currently driven,
  // then let the DUT take the edge and settle.
  task automatic step();
    logic [7:0] nrd;
    if (reset) begin
      m_loading = 1'b1; m_ptr = 0; m_rd = 8'h00; m_io = 8'h00; m_iov = 1'b0;
    end else if (m_loading) begin
      m_iov = 1'b0;
      if (load_valid) begin
        m_mem[m_ptr] = load_data;
        if (load_last || m_ptr == 255) m_loading = 1'b0;
        else m_ptr = m_ptr + 1;
      end
    end else begin
      nrd = m_rd;
      if (rd_ram_en) begin
        if (rd_ram_addr == 8'hFF) nrd = io_in_data;
        else if (wr_ram_en && wr_ram_addr == rd_ram_addr) nrd = wr_ram_data;
        else nrd = m_mem[rd_ram_addr];
      end
      m_iov = 1'b0;
      if (wr_ram_en) begin
        if (wr_ram_addr == 8'hFF) begin m_io = wr_ram_data; m_iov = 1'b1; end
        else m_mem[wr_ram_addr] = wr_ram_data;
      end
      m_rd = nrd;
    end
    @(posedge clk);
    #1;
  endtask

  // Drivers
  task automatic idle();
    rd_ram_en = 1'b0; wr_ram_en = 1'b0; load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic drive_load(input logic [7:0] d, input logic last);
    idle();
    load_valid = 1'b1; load_data = d; load_last = last;
  endtask

  task automatic drive_run(input logic re, input logic [7:0] ra,
                           input logic we, input logic [7:0] wa, input logic [7:0] wd);
    idle();
    rd_ram_en = re; rd_ram_addr = ra; wr_ram_en = we; wr_ram_addr = wa; wr_ram_data = wd;
  endtask

  // Scenarios
  task automatic test_reset();
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    total++; if (rd_ram_data !== 8'h00) begin bad++; $display("FAIL reset_rd got=%h exp=00", rd_ram_data); end
    total++; if (io_out_data !== 8'h00) begin bad++; $display("FAIL reset_io_data got=%h exp=00", io_out_data); end
    total++; if (io_out_valid !== 1'b0) begin bad++; $display("FAIL reset_io_valid got=%b exp=0", io_out_valid); end
    total++; if (load_ready !== 1'b1 || hold_cpu !== 1'b1) begin
      bad++; $display("FAIL reset_load_state got=%b%b exp=11", load_ready, hold_cpu);
    end
  endtask

  task automatic test_load();
    drive_load(8'd10, 1'b0); step();
    drive_load(8'd20, 1'b0); step();
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL load_mid_ready got=%b exp=1", load_ready); end
    drive_load(8'd30, 1'b1); step();
    idle();
    total++; if (load_ready !== 1'b0 || hold_cpu !== 1'b0) begin
      bad++; $display("FAIL load_done got=%b%b exp=00", load_ready, hold_cpu);
    end
    // Extra valid in RUN is ignored.
    drive_load(8'hEE, 1'b0); step();
    drive_run(1'b1, 8'd1, 1'b0, 8'd0, 8'd0); step();
    idle();
    total++; if (rd_ram_data !== 8'h14) begin bad++; $display("FAIL load_read1 got=%h exp=14", rd_ram_data); end
    drive_run(1'b1, 8'd3, 1'b0, 8'd0, 8'd0); step();
    total++; if (rd_ram_data !== m_rd) begin bad++; $display("FAIL load_ignored_in_run got=%h exp=%h", rd_ram_data, m_rd); end
    idle(); step();
    total++; if (rd_ram_data !== m_rd) begin bad++; $display("FAIL read_hold got=%h exp=%h", rd_ram_data, m_rd); end
  endtask

  task automatic test_pointer_limit();
    logic [7:0] first;
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive_load(8'($urandom_range(0, 255)), 1'b0);
      if (i == 0) first = load_data;
      step();
      if (i == 254) begin
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL ptr_254_ready got=%b exp=1", load_ready); end
      end
    end
    total++; if (load_ready !== 1'b0 || hold_cpu !== 1'b0) begin
      bad++; $display("FAIL ptr_limit_run got=%b%b exp=00", load_ready, hold_cpu);
    end
    drive_load(~first, 1'b0); step();
    drive_run(1'b1, 8'd0, 1'b0, 8'd0, 8'd0); step();
    idle();
    total++; if (rd_ram_data !== first) begin bad++; $display("FAIL ptr_mem0 got=%h exp=%h", rd_ram_data, first); end
    drive_run(1'b1, 8'd254, 1'b0, 8'd0, 8'd0); step();
    total++; if (rd_ram_data !== m_rd) begin bad++; $display("FAIL ptr_mem254 got=%h exp=%h", rd_ram_data, m_rd); end
    idle();
  endtask

  task automatic test_forwarding();
    drive_run(1'b0, 8'd0, 1'b1, 8'd5, 8'hAA); step();
    drive_run(1'b1, 8'd5, 1'b1, 8'd5, 8'h55); step();
    total++; if (rd_ram_data !== 8'h55) begin bad++; $display("FAIL fwd_same_edge got=%h exp=55", rd_ram_data); end
    drive_run(1'b1, 8'd5, 1'b0, 8'd0, 8'h00); step();
    total++; if (rd_ram_data !== 8'h55) begin bad++; $display("FAIL fwd_stored got=%h exp=55", rd_ram_data); end
    idle();
  endtask

  task automatic test_io();
    logic [7:0] mem_ff;
    mem_ff = m_mem[255];
    drive_run(1'b0, 8'd0, 1'b1, 8'hFF, 8'h3C); step();
    total++; if (io_out_valid !== 1'b1 || io_out_data !== 8'h3C) begin
      bad++; $display("FAIL io_first got=%b/%h exp=1/3c", io_out_valid, io_out_data);
    end
    drive_run(1'b0, 8'd0, 1'b1, 8'hFF, 8'h3D); step();
    total++; if (io_out_valid !== 1'b1 || io_out_data !== 8'h3D) begin
      bad++; $display("FAIL io_second got=%b/%h exp=1/3d", io_out_valid, io_out_data);
    end
    idle(); step();
    total++; if (io_out_valid !== 1'b0 || io_out_data !== 8'h3D) begin
      bad++; $display("FAIL io_after got=%b/%h exp=0/3d", io_out_valid, io_out_data);
    end
    total++; if (dut.u_ram.mem[255] !== mem_ff) begin
      bad++; $display("FAIL io_mem_ff got=%h exp=%h", dut.u_ram.mem[255], mem_ff);
    end
    io_in_data = 8'h99;
    drive_run(1'b1, 8'hFF, 1'b0, 8'd0, 8'd0); step();
    idle();
    total++; if (rd_ram_data !== 8'h99) begin bad++; $display("FAIL io_read got=%h exp=99", rd_ram_data); end
  endtask

  task automatic test_random_run();
    for (int i = 0; i < 300; i++) begin
      drive_run(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      // Bias addresses so forwarding and IO cases occur often.
      if ($urandom_range(0, 3) == 0) wr_ram_addr = rd_ram_addr;
      if ($urandom_range(0, 7) == 0) wr_ram_addr = 8'hFF;
      if ($urandom_range(0, 7) == 0) rd_ram_addr = 8'hFF;
      io_in_data = 8'($urandom_range(0, 255));
      step();
      total++; if (rd_ram_data !== m_rd) begin bad++; $display("FAIL rand_rd i=%0d got=%h exp=%h", i, rd_ram_data, m_rd); end
      total++; if (io_out_valid !== m_iov || io_out_data !== m_io) begin
        bad++; $display("FAIL rand_io i=%0d got=%b/%h exp=%b/%h", i, io_out_valid, io_out_data, m_iov, m_io);
      end
    end
    idle();
  endtask

  task automatic test_hold();
    logic [7:0] io_before;
    logic [7:0] snap [256];
    for (int a = 0; a < 256; a++) snap[a] = dut.u_ram.mem[a];
    io_before = m_io;
    idle(); step();
    for (int i = 0; i < 20; i++) begin
      wr_ram_en = 1'b0; wr_ram_addr = 8'($urandom_range(0, 255)); wr_ram_data = 8'bz;
      step();
      total++; if (io_out_valid !== 1'b0 || io_out_data !== io_before) begin
        bad++; $display("FAIL hold_io i=%0d got=%b/%h exp=0/%h", i, io_out_valid, io_out_data, io_before);
      end
    end
    for (int a = 0; a < 256; a++) begin
      total++; if (dut.u_ram.mem[a] !== snap[a]) begin
        bad++; $display("FAIL hold_mem a=%0d got=%h exp=%h", a, dut.u_ram.mem[a], snap[a]);
      end
    end
    wr_ram_data = 8'h00;
  endtask

  task automatic test_reset_in_run();
    logic [7:0] old7;
    old7 = m_mem[7];
    drive_run(1'b1, 8'd7, 1'b1, 8'd7, ~old7);
    reset = 1'b1; step(); reset = 1'b0;
    idle();
    total++; if (rd_ram_data !== 8'h00 || io_out_data !== 8'h00 || io_out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_run_outs got=%h/%h/%b exp=00/00/0", rd_ram_data, io_out_data, io_out_valid);
    end
    total++; if (load_ready !== 1'b1 || hold_cpu !== 1'b1) begin
      bad++; $display("FAIL rst_run_state got=%b%b exp=11", load_ready, hold_cpu);
    end
    // Reads and writes are ignored while loading.
    drive_run(1'b1, 8'd7, 1'b1, 8'd9, ~m_mem[9]); step();
    total++; if (rd_ram_data !== 8'h00) begin bad++; $display("FAIL load_rd_hold got=%h exp=00", rd_ram_data); end
    // Abandon a partial load, then confirm the pointer restarts at 0.
    drive_load(8'h11, 1'b0); step();
    drive_load(8'h22, 1'b0); step();
    idle(); reset = 1'b1; step(); reset = 1'b0;
    drive_load(8'h77, 1'b1); step();
    drive_run(1'b1, 8'd0, 1'b0, 8'd0, 8'd0); step();
    total++; if (rd_ram_data !== 8'h77) begin bad++; $display("FAIL reload_ptr0 got=%h exp=77", rd_ram_data); end
    drive_run(1'b1, 8'd1, 1'b0, 8'd0, 8'd0); step();
    total++; if (rd_ram_data !== m_rd) begin bad++; $display("FAIL reload_mem1 got=%h exp=%h", rd_ram_data, m_rd); end
    drive_run(1'b1, 8'd7, 1'b0, 8'd0, 8'd0); step();
    total++; if (rd_ram_data !== old7) begin bad++; $display("FAIL rst_mem7 got=%h exp=%h", rd_ram_data, old7); end
    drive_run(1'b1, 8'd9, 1'b0, 8'd0, 8'd0); step();
    total++; if (rd_ram_data !== m_rd) begin bad++; $display("FAIL load_wr_ignored got=%h exp=%h", rd_ram_data, m_rd); end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    rd_ram_addr = 8'd0; wr_ram_addr = 8'd0; wr_ram_data = 8'd0;
    load_data = 8'd0; io_in_data = 8'd0;
    idle();
    for (int a = 0; a < 256; a++) m_mem[a] = 8'hxx;
    m_loading = 1'b1; m_ptr = 0; m_rd = 8'h00; m_io = 8'h00; m_iov = 1'b0;

    test_reset();
    test_load();
    test_pointer_limit();
    test_forwarding();
    test_io();
    test_random_run();
    test_hold();
    test_reset_in_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
